// File: rtl/lisp_heap_writer_pkg.sv
// Shared Lisp heap definitions: object tags, writer FSM states and object sizing.
package lisp_heap_writer_pkg;

  localparam int LISP_ADDR_WIDTH = 16;
  localparam int LISP_DATA_WIDTH = 16;

  localparam logic [LISP_DATA_WIDTH-1:0] TYPE_NUMBER = 16'h0001;
  localparam logic [LISP_DATA_WIDTH-1:0] TYPE_CONS   = 16'h0002;

  localparam logic [LISP_ADDR_WIDTH-1:0] HEAP_BASE_DEFAULT = 16'h0100;

  typedef enum logic [2:0] {
    IDLE,
    WR_TAG,
    WR_CAR,
    WR_CDR,
    RESP
  } heap_state_t;

  // Words occupied by an object (tag + payload); 0 marks an unknown tag.
  function automatic logic [1:0] obj_words(input logic [LISP_DATA_WIDTH-1:0] tag);
    case (tag)
      TYPE_NUMBER: obj_words = 2'd2;
      TYPE_CONS:   obj_words = 2'd3;
      default:     obj_words = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/lisp_heap_writer.sv
// Heap write engine: serialises NUMBER/CONS objects at a bump-pointer address
// through the shared memory port and returns the object's base address.
module lisp_heap_writer
  import lisp_heap_writer_pkg::*;
#(
  parameter int                    ADDR_WIDTH = LISP_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = LISP_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] HEAP_BASE  = HEAP_BASE_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] HEAP_LIMIT = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_done,
  input  logic                  heap_clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_tag,
  input  logic [DATA_WIDTH-1:0] req_car,
  input  logic [DATA_WIDTH-1:0] req_cdr,
  output logic                  resp_valid,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  resp_err,
  output logic                  heap_full,
  output logic [ADDR_WIDTH-1:0] free_ptr,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  localparam logic [ADDR_WIDTH:0] ONE_EXT = {{ADDR_WIDTH{1'b0}}, 1'b1};

  heap_state_t           state, state_nxt;
  logic [DATA_WIDTH-1:0] tag_q, car_q, cdr_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] resp_addr_q;
  // One extra bit so an exact fit at the top of memory cannot wrap to a low address.
  logic [ADDR_WIDTH:0]   free_q;
  logic                  err_q;
  logic                  full_q;

  logic                  accept;
  logic [1:0]            req_words;
  logic [1:0]            cur_words;
  logic [ADDR_WIDTH:0]   req_size;
  logic [ADDR_WIDTH:0]   cur_size;
  logic                  known;
  logic                  fits;

  assign req_ready = (state == IDLE) && boot_done && !heap_clear && !rst;
  assign accept    = req_valid && req_ready;
  assign req_words = obj_words(req_tag);
  assign cur_words = obj_words(tag_q);
  assign req_size  = {{(ADDR_WIDTH-1){1'b0}}, req_words};
  assign cur_size  = {{(ADDR_WIDTH-1){1'b0}}, cur_words};
  assign known     = (req_words != 2'd0);
  assign fits      = (free_q + req_size - ONE_EXT) <= {1'b0, HEAP_LIMIT};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (known && fits) ? WR_TAG : RESP;
      WR_TAG:  if (mem_gnt) state_nxt = WR_CAR;
      WR_CAR:  if (mem_gnt) state_nxt = (cur_words == 2'd3) ? WR_CDR : RESP;
      WR_CDR:  if (mem_gnt) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      WR_TAG: begin
        mem_req   = 1'b1;
        mem_addr  = base_q;
        mem_wdata = tag_q;
      end
      WR_CAR: begin
        mem_req   = 1'b1;
        mem_addr  = base_q + ADDR_WIDTH'(1);
        mem_wdata = car_q;
      end
      WR_CDR: begin
        mem_req   = 1'b1;
        mem_addr  = base_q + ADDR_WIDTH'(2);
        mem_wdata = cdr_q;
      end
      default: ;
    endcase
  end

  // NOTE: mem_we follows mem_gnt combinationally so a stalled write never
  // strobes; address and data come only from registers, so they stay stable.
  assign mem_we     = mem_req && mem_gnt;
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_addr  = resp_valid ? base_q : resp_addr_q;
  assign heap_full  = full_q;
  assign free_ptr   = free_q[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      free_q      <= {1'b0, HEAP_BASE};
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      base_q      <= '0;
      resp_addr_q <= '0;
      tag_q       <= '0;
      car_q       <= '0;
      cdr_q       <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (heap_clear) begin
          free_q <= {1'b0, HEAP_BASE};
          full_q <= 1'b0;
        end else if (accept) begin
          tag_q  <= req_tag;
          car_q  <= req_car;
          cdr_q  <= req_cdr;
          base_q <= free_q[ADDR_WIDTH-1:0];
          err_q  <= !(known && fits);
          if (known && !fits) full_q <= 1'b1;
        end
      end
      if (state == RESP) begin
        resp_addr_q <= base_q;
        if (!err_q) free_q <= {1'b0, base_q} + cur_size;
      end
    end
  end

endmodule

// File: tb/tb_lisp_heap_writer.sv
// Scoreboard bench for lisp_heap_writer: directed allocations, stalls, heap limit, clear and reset.
module tb_lisp_heap_writer;
  import lisp_heap_writer_pkg::*;

  localparam logic [15:0] LIMIT = 16'h0108;

  logic        clk, rst, boot_done, heap_clear;
  logic        req_valid, req_ready;
  logic [15:0] req_tag, req_car, req_cdr;
  logic        resp_valid, resp_err, heap_full;
  logic [15:0] resp_addr, free_ptr;
  logic        mem_req, mem_gnt, mem_we;
  logic [15:0] mem_addr, mem_wdata;

  lisp_heap_writer #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .HEAP_BASE(16'h0100), .HEAP_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .boot_done(boot_done), .heap_clear(heap_clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_car(req_car), .req_cdr(req_cdr), .resp_valid(resp_valid),
    .resp_addr(resp_addr), .resp_err(resp_err), .heap_full(heap_full),
    .free_ptr(free_ptr), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  int          wr0;
  logic [15:0] mem [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response and mirrors memory writes.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual addr=%h err=%b expected no response", resp_addr, resp_err);
      end else begin
        e = exp_q.pop_front();
        check("resp_addr", resp_addr, e.addr);
        check("resp_err", resp_err, e.err);
        check("resp_cycle", cyc, e.cyc);
      end
    end
    if (mem_we) begin
      mem[int'(mem_addr)] = mem_wdata;
      wr_count++;
      check("we_with_gnt", {mem_req, mem_gnt}, 2'b11);
    end
  end

  // Present a request, wait (bounded) for the accept edge, then queue the expected response.
  task automatic issue(input logic [15:0] tag, input logic [15:0] car, input logic [15:0] cdr,
                       input logic exp_err, input logic [15:0] exp_addr, input int lat, input bit push);
    req_tag   = tag;
    req_car   = car;
    req_cdr   = cdr;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    check("req_ready_wait", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) exp_q.push_back('{addr: exp_addr, err: exp_err, cyc: cyc + lat});
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("resp_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_resp_addr", resp_addr, 16'h0000);
    check("rst_heap_full", heap_full, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_free_ptr", free_ptr, 16'h0100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; boot_done = 1'b0; heap_clear = 1'b0; req_valid = 1'b0;
    req_tag = '0; req_car = '0; req_cdr = '0; mem_gnt = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("ready_no_boot", req_ready, 1'b0);
    end
    @(posedge clk); #1;
    boot_done = 1'b1;

    // NUMBER 002A at the heap base
    issue(TYPE_NUMBER, 16'h002A, 16'h0000, 1'b0, 16'h0100, 2, 1'b1);
    wait_resp();
    check("t1_free", free_ptr, 16'h0102);
    check("t1_mem0", mem[32'h0100], TYPE_NUMBER);
    check("t1_mem1", mem[32'h0101], 16'h002A);

    // CONS (0100 . 0000)
    issue(TYPE_CONS, 16'h0100, 16'h0000, 1'b0, 16'h0102, 3, 1'b1);
    wait_resp();
    check("t2_free", free_ptr, 16'h0105);
    check("t2_mem0", mem[32'h0102], TYPE_CONS);
    check("t2_mem1", mem[32'h0103], 16'h0100);
    check("t2_mem2", mem[32'h0104], 16'h0000);

    // Grant withheld for 5 cycles while in WR_CAR
    issue(TYPE_NUMBER, 16'h1234, 16'h0000, 1'b0, 16'h0105, 7, 1'b1);
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_we", mem_we, 1'b0);
      check("stall_req", mem_req, 1'b1);
      check("stall_addr", mem_addr, 16'h0106);
      check("stall_data", mem_wdata, 16'h1234);
      @(posedge clk);
    end
    #1;
    mem_gnt = 1'b1;
    wait_resp();
    check("t3_free", free_ptr, 16'h0107);
    check("t3_mem0", mem[32'h0105], TYPE_NUMBER);
    check("t3_mem1", mem[32'h0106], 16'h1234);

    // CONS needs 0107..0109, past the limit 0108: rejected, heap_full set
    wr0 = wr_count;
    issue(TYPE_CONS, 16'h0107, 16'h0000, 1'b1, 16'h0107, 0, 1'b1);
    wait_resp();
    check("t4_full", heap_full, 1'b1);
    check("t4_free", free_ptr, 16'h0107);
    check("t4_nowrite", wr_count, wr0);
    // NUMBER fits exactly at 0107..0108
    issue(TYPE_NUMBER, 16'h5555, 16'h0000, 1'b0, 16'h0107, 2, 1'b1);
    wait_resp();
    check("t4_exact_free", free_ptr, 16'h0109);
    check("t4_exact_mem0", mem[32'h0107], TYPE_NUMBER);
    check("t4_exact_mem1", mem[32'h0108], 16'h5555);
    check("t4_full_sticky", heap_full, 1'b1);
    // Heap exhausted: any further object is rejected
    issue(TYPE_NUMBER, 16'h0001, 16'h0000, 1'b1, 16'h0109, 0, 1'b1);
    wait_resp();
    check("t4_after_free", free_ptr, 16'h0109);

    // Unknown tag
    wr0 = wr_count;
    issue(16'hBEEF, 16'h0001, 16'h0002, 1'b1, 16'h0109, 0, 1'b1);
    wait_resp();
    check("t5_nowrite", wr_count, wr0);
    check("t5_free", free_ptr, 16'h0109);

    // heap_clear beats a simultaneous request
    heap_clear = 1'b1;
    req_valid  = 1'b1;
    req_tag    = TYPE_NUMBER;
    @(negedge clk);
    check("clr_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    heap_clear = 1'b0;
    req_valid  = 1'b0;
    @(negedge clk);
    check("clr_free", free_ptr, 16'h0100);
    check("clr_full", heap_full, 1'b0);
    check("clr_no_accept", mem_req, 1'b0);
    @(posedge clk); #1;
    issue(TYPE_NUMBER, 16'h0777, 16'h0000, 1'b0, 16'h0100, 2, 1'b1);
    wait_resp();
    check("clr_alloc_free", free_ptr, 16'h0102);

    // Reset while writing the cdr word: object abandoned, no response
    issue(TYPE_CONS, 16'hAAAA, 16'hBBBB, 1'b0, 16'h0102, 3, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_cdr_addr", mem_addr, 16'h0104);
    rst       = 1'b1;
    boot_done = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t6_ready_no_boot", req_ready, 1'b0);
      check("t6_no_resp", resp_valid, 1'b0);
    end
    @(posedge clk); #1;
    boot_done = 1'b1;
    @(negedge clk);
    check("t6_ready_boot", req_ready, 1'b1);
    check("t6_free", free_ptr, 16'h0100);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
